// File: rtl/move_cmd_queue_pkg.sv
// Shared encodings for the snake keyboard front end: directions, key bytes,
// controller states and the reverse-direction helper.
package move_cmd_queue_pkg;

    localparam logic [2:0] DIR_UP    = 3'd0;
    localparam logic [2:0] DIR_DOWN  = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_NONE  = 3'd7;

    localparam logic [7:0] KEY_W      = 8'h77;
    localparam logic [7:0] KEY_S      = 8'h73;
    localparam logic [7:0] KEY_A      = 8'h61;
    localparam logic [7:0] KEY_D      = 8'h64;
    localparam logic [7:0] KEY_8      = 8'h38;
    localparam logic [7:0] KEY_5      = 8'h35;
    localparam logic [7:0] KEY_4      = 8'h34;
    localparam logic [7:0] KEY_6      = 8'h36;
    localparam logic [7:0] KEY_P      = 8'h70;
    localparam logic [7:0] KEY_R      = 8'h72;
    localparam logic [7:0] KEY_B      = 8'h62;
    localparam logic [7:0] KEY_K      = 8'h6b;
    localparam logic [7:0] ECHO_REJECT = 8'h21;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    // NONE maps to NONE so an idle player accepts any first direction.
    function automatic logic [2:0] reverse_dir(input logic [2:0] d);
        logic [2:0] r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/move_cmd_queue_if.sv
// Bus between the UART/game-core side and the keyboard command queue.
interface move_cmd_queue_if #(
    parameter int N_PLAYERS = 1,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                      rx_valid;
    logic [7:0]                rx_byte;
    logic                      step;
    logic                      tx_busy;
    logic                      tx_start;
    logic [7:0]                tx_byte;
    logic [3*N_PLAYERS-1:0]    dir;
    logic [CW*N_PLAYERS-1:0]   q_count;
    logic                      background;
    logic                      barrier_control;
    logic                      restart;
    logic                      paused;
    logic [N_PLAYERS-1:0]      overflow;

    modport master (
        output rx_valid, rx_byte, step, tx_busy,
        input  tx_start, tx_byte, dir, q_count, background, barrier_control,
               restart, paused, overflow
    );

    modport slave (
        input  rx_valid, rx_byte, step, tx_busy,
        output tx_start, tx_byte, dir, q_count, background, barrier_control,
               restart, paused, overflow
    );
endinterface

// File: rtl/move_cmd_queue_dir_fifo.sv
// Small direction FIFO: DEPTH x 3 bits with simultaneous push/pop, exposing
// head, tail and occupancy so the decoder can validate against the tail.
module dir_fifo
    import move_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [2:0]    din,
    output logic [2:0]    head,
    output logic [2:0]    tail,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [2:0]    mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // A pop frees a slot in the same edge, so a full queue can still take a push.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= DIR_NONE;
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign tail  = mem_r[wr_ptr_r - PTR_ONE];
    assign count = count_r;
    assign empty = (count_r == '0);
    assign full  = (count_r == CNT_FULL);

endmodule

// File: rtl/move_cmd_queue.sv
// Keyboard command front end: decodes UART bytes into per-player direction
// queues and control pulses, and echoes accepted/rejected keys back.
module move_cmd_queue
    import move_cmd_queue_pkg::*;
#(
    parameter int N_PLAYERS  = 1,
    parameter int DEPTH      = 4,
    parameter int INIT_DELAY = 100000,
    parameter int ECHO       = 1
) (
    input logic              clk,
    input logic              reset,
    move_cmd_queue_if.slave  bus
);
    localparam int             CW        = $clog2(DEPTH + 1);
    localparam int             ICW       = $clog2(INIT_DELAY + 1);
    localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_DELAY - 1);
    localparam logic [ICW-1:0] INIT_ONE  = ICW'(1);

    logic [1:0]           state_r;
    logic [ICW-1:0]       init_cnt_r;
    logic                 paused_r;
    logic                 restart_r;
    logic                 background_r;
    logic                 barrier_r;
    logic                 echo_full_r;
    logic [7:0]           echo_byte_r;
    logic                 tx_start_r;
    logic [7:0]           tx_byte_r;

    logic                 run_s;
    logic                 rx_live_s;
    logic                 dir_key_s;
    logic                 key_player_s;
    logic [2:0]           key_dir_s;
    logic                 ctl_key_s;
    logic                 is_p_s;
    logic                 is_r_s;
    logic                 is_b_s;
    logic                 is_k_s;
    logic [N_PLAYERS-1:0] hit_vec_s;
    logic [N_PLAYERS-1:0] push_vec_s;
    logic                 echo_load_s;
    logic [7:0]           echo_val_s;
    logic                 send_s;

    // Byte decode; player-1 keys only map when a second player exists.
    always_comb begin
        dir_key_s    = 1'b0;
        key_player_s = 1'b0;
        key_dir_s    = DIR_NONE;
        ctl_key_s    = 1'b0;
        case (bus.rx_byte)
            KEY_W:   begin dir_key_s = 1'b1; key_dir_s = DIR_UP;    end
            KEY_S:   begin dir_key_s = 1'b1; key_dir_s = DIR_DOWN;  end
            KEY_A:   begin dir_key_s = 1'b1; key_dir_s = DIR_LEFT;  end
            KEY_D:   begin dir_key_s = 1'b1; key_dir_s = DIR_RIGHT; end
            KEY_8:   begin dir_key_s = (N_PLAYERS == 2); key_player_s = 1'b1; key_dir_s = DIR_UP;    end
            KEY_5:   begin dir_key_s = (N_PLAYERS == 2); key_player_s = 1'b1; key_dir_s = DIR_DOWN;  end
            KEY_4:   begin dir_key_s = (N_PLAYERS == 2); key_player_s = 1'b1; key_dir_s = DIR_LEFT;  end
            KEY_6:   begin dir_key_s = (N_PLAYERS == 2); key_player_s = 1'b1; key_dir_s = DIR_RIGHT; end
            KEY_P, KEY_R, KEY_B, KEY_K: ctl_key_s = 1'b1;
            default: ctl_key_s = 1'b0;
        endcase
    end

    assign run_s     = (state_r == S_RUN);
    assign rx_live_s = bus.rx_valid && (state_r != S_INIT);
    assign is_p_s    = rx_live_s && (bus.rx_byte == KEY_P);
    assign is_r_s    = rx_live_s && (bus.rx_byte == KEY_R);
    assign is_b_s    = rx_live_s && (bus.rx_byte == KEY_B);
    assign is_k_s    = rx_live_s && (bus.rx_byte == KEY_K);

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        logic          hit_s;
        logic          legal_s;
        logic          pop_s;
        logic          push_s;
        logic          drop_s;
        logic [2:0]    ref_s;
        logic [2:0]    head_s;
        logic [2:0]    tail_s;
        logic [CW-1:0] count_s;
        logic          empty_s;
        logic          full_s;
        logic [2:0]    dir_r;
        logic          ovf_r;

        // Validate against the newest queued move, or the live heading if none.
        always_comb begin
            hit_s   = rx_live_s && dir_key_s && (key_player_s == (p != 0));
            ref_s   = empty_s ? dir_r : tail_s;
            legal_s = (key_dir_s != ref_s) && (key_dir_s != reverse_dir(ref_s));
            pop_s   = bus.step && run_s && !empty_s;
            push_s  = hit_s && run_s && legal_s && (!full_s || pop_s);
            drop_s  = hit_s && run_s && legal_s && full_s && !pop_s;
        end

        dir_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (is_r_s),
            .push  (push_s),
            .pop   (pop_s),
            .din   (key_dir_s),
            .head  (head_s),
            .tail  (tail_s),
            .count (count_s),
            .empty (empty_s),
            .full  (full_s)
        );

        // Current heading and sticky overflow flag.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dir_r <= DIR_NONE;
                ovf_r <= 1'b0;
            end else if (is_r_s) begin
                dir_r <= DIR_NONE;
                ovf_r <= 1'b0;
            end else begin
                if (pop_s)  dir_r <= head_s;
                if (drop_s) ovf_r <= 1'b1;
            end
        end

        assign hit_vec_s[p]           = hit_s;
        assign push_vec_s[p]          = push_s;
        assign bus.dir[3*p +: 3]      = dir_r;
        assign bus.q_count[CW*p +: CW] = count_s;
        assign bus.overflow[p]        = ovf_r;
    end

    // Controller state: power-up quiet period, then run/pause toggling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_INIT;
            init_cnt_r <= '0;
            paused_r   <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    if (init_cnt_r == INIT_LAST) state_r <= S_RUN;
                    else                         init_cnt_r <= init_cnt_r + INIT_ONE;
                end
                S_RUN: begin
                    if (!is_r_s && is_p_s) begin
                        state_r  <= S_PAUSE;
                        paused_r <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (is_r_s || is_p_s) begin
                        state_r  <= S_RUN;
                        paused_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= S_INIT;
                    paused_r <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle control pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            restart_r    <= 1'b0;
            background_r <= 1'b0;
            barrier_r    <= 1'b0;
        end else begin
            restart_r    <= is_r_s;
            background_r <= is_b_s;
            barrier_r    <= is_k_s;
        end
    end

    // Echo selection: a direction key is echoed as itself only if it was queued.
    always_comb begin
        echo_load_s = (ECHO != 0) && rx_live_s && (ctl_key_s || (|hit_vec_s));
        if ((|hit_vec_s) && !(|push_vec_s)) echo_val_s = ECHO_REJECT;
        else                                echo_val_s = bus.rx_byte;
        send_s = echo_full_r && !bus.tx_busy;
    end

    // Single-entry echo holding register feeding the transmitter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_full_r <= 1'b0;
            echo_byte_r <= 8'h00;
            tx_start_r  <= 1'b0;
            tx_byte_r   <= 8'h00;
        end else begin
            tx_start_r <= send_s;
            if (send_s) begin
                tx_byte_r   <= echo_byte_r;
                echo_full_r <= 1'b0;
            end else if (echo_load_s && !echo_full_r) begin
                echo_byte_r <= echo_val_s;
                echo_full_r <= 1'b1;
            end
        end
    end

    assign bus.tx_start        = (ECHO != 0) ? tx_start_r : 1'b0;
    assign bus.tx_byte         = tx_byte_r;
    assign bus.background      = background_r;
    assign bus.barrier_control = barrier_r;
    assign bus.restart         = restart_r;
    assign bus.paused          = paused_r;

endmodule

// File: tb/tb_move_cmd_queue.sv
// Directed bench for move_cmd_queue (1 player, depth 4, short init delay).
module tb_move_cmd_queue;

    localparam int INIT_DELAY = 100;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   tx_cnt;
    int   busy_viol;
    logic [7:0] last_tx;

    move_cmd_queue_if #(.N_PLAYERS(1), .DEPTH(4)) bus ();

    move_cmd_queue #(
        .N_PLAYERS (1),
        .DEPTH     (4),
        .INIT_DELAY(INIT_DELAY),
        .ECHO      (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmit monitor: counts echo strobes and remembers the last byte sent.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            tx_cnt  <= tx_cnt + 1;
            last_tx <= bus.tx_byte;
            if (bus.tx_busy === 1'b1) busy_viol <= busy_viol + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic with_step);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        bus.step     = with_step;
        tick();
        bus.rx_valid = 1'b0;
        bus.step     = 1'b0;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #12;
        total++; if (bus.dir !== 3'd7) begin bad++; $display("FAIL reset_dir got=%0d exp=7", bus.dir); end
        total++; if (bus.q_count !== 3'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", bus.q_count); end
        total++; if (bus.tx_start !== 1'b0 || bus.tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx got=%b/%h exp=0/00", bus.tx_start, bus.tx_byte); end
        total++; if (bus.paused !== 1'b0 || bus.overflow !== 1'b0 || bus.restart !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=000", bus.paused, bus.overflow, bus.restart); end
        @(negedge clk);
        reset = 1'b1;
        repeat (50) tick();
        send(8'h77, 1'b0);
        total++; if (bus.q_count !== 3'd0) begin bad++; $display("FAIL init_ignore_q got=%0d exp=0", bus.q_count); end
        settle();
        total++; if (tx_cnt !== 0) begin bad++; $display("FAIL init_ignore_tx got=%0d exp=0", tx_cnt); end
        repeat (INIT_DELAY) tick();
        send(8'h77, 1'b0);
        total++; if (bus.q_count !== 3'd1) begin bad++; $display("FAIL first_push_q got=%0d exp=1", bus.q_count); end
        tick();
        total++; if (bus.tx_start !== 1'b1 || bus.tx_byte !== 8'h77) begin bad++; $display("FAIL first_echo got=%b/%h exp=1/77", bus.tx_start, bus.tx_byte); end
        tick();
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL echo_one_cycle got=%b exp=0", bus.tx_start); end
        do_step();
        total++; if (bus.dir !== 3'd0 || bus.q_count !== 3'd0) begin bad++; $display("FAIL first_pop got=%0d/%0d exp=0/0", bus.dir, bus.q_count); end
    endtask

    task automatic test_reject();
        int c0;
        c0 = tx_cnt;
        send(8'h73, 1'b0);
        total++; if (bus.q_count !== 3'd0) begin bad++; $display("FAIL reverse_q got=%0d exp=0", bus.q_count); end
        settle();
        total++; if (tx_cnt !== c0 + 1 || last_tx !== 8'h21) begin bad++; $display("FAIL reverse_echo got=%0d/%h exp=%0d/21", tx_cnt, last_tx, c0 + 1); end
        send(8'h61, 1'b0);
        total++; if (bus.q_count !== 3'd1) begin bad++; $display("FAIL left_q got=%0d exp=1", bus.q_count); end
        settle();
        total++; if (last_tx !== 8'h61) begin bad++; $display("FAIL left_echo got=%h exp=61", last_tx); end
        send(8'h64, 1'b0);
        total++; if (bus.q_count !== 3'd1) begin bad++; $display("FAIL tail_reverse_q got=%0d exp=1", bus.q_count); end
        settle();
        total++; if (last_tx !== 8'h21) begin bad++; $display("FAIL tail_reverse_echo got=%h exp=21", last_tx); end
        do_step();
        total++; if (bus.dir !== 3'd2 || bus.q_count !== 3'd0) begin bad++; $display("FAIL left_pop got=%0d/%0d exp=2/0", bus.dir, bus.q_count); end
    endtask

    task automatic test_overflow();
        logic [7:0] seq [4];
        seq = '{8'h77, 8'h61, 8'h77, 8'h61};
        for (int i = 0; i < 4; i++) begin
            send(seq[i], 1'b0);
            settle();
            total++; if (bus.q_count !== 3'(i + 1)) begin bad++; $display("FAIL fill_q%0d got=%0d exp=%0d", i, bus.q_count, i + 1); end
        end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_no_ovf got=%b exp=0", bus.overflow); end
        send(8'h77, 1'b0);
        total++; if (bus.q_count !== 3'd4 || bus.overflow !== 1'b1) begin bad++; $display("FAIL drop got=%0d/%b exp=4/1", bus.q_count, bus.overflow); end
        settle();
        total++; if (last_tx !== 8'h21) begin bad++; $display("FAIL drop_echo got=%h exp=21", last_tx); end
        do_step();
        total++; if (bus.dir !== 3'd0 || bus.q_count !== 3'd3) begin bad++; $display("FAIL ovf_pop got=%0d/%0d exp=0/3", bus.dir, bus.q_count); end
        send(8'h77, 1'b0);
        settle();
        send(8'h61, 1'b1);
        total++; if (bus.q_count !== 3'd4 || bus.dir !== 3'd2) begin bad++; $display("FAIL full_push_pop got=%0d/%0d exp=4/2", bus.q_count, bus.dir); end
        settle();
        repeat (4) do_step();
        total++; if (bus.dir !== 3'd2 || bus.q_count !== 3'd0 || bus.overflow !== 1'b1) begin bad++; $display("FAIL drain got=%0d/%0d/%b exp=2/0/1", bus.dir, bus.q_count, bus.overflow); end
    endtask

    task automatic test_same_cycle();
        send(8'h77, 1'b0);
        settle();
        do_step();
        send(8'h61, 1'b1);
        total++; if (bus.dir !== 3'd0 || bus.q_count !== 3'd1) begin bad++; $display("FAIL no_bypass got=%0d/%0d exp=0/1", bus.dir, bus.q_count); end
        settle();
        do_step();
        total++; if (bus.dir !== 3'd2 || bus.q_count !== 3'd0) begin bad++; $display("FAIL late_pop got=%0d/%0d exp=2/0", bus.dir, bus.q_count); end
    endtask

    task automatic test_pause_restart();
        send(8'h77, 1'b0);
        settle();
        send(8'h70, 1'b0);
        total++; if (bus.paused !== 1'b1) begin bad++; $display("FAIL pause_on got=%b exp=1", bus.paused); end
        settle();
        do_step();
        total++; if (bus.dir !== 3'd2 || bus.q_count !== 3'd1) begin bad++; $display("FAIL pause_step got=%0d/%0d exp=2/1", bus.dir, bus.q_count); end
        send(8'h64, 1'b0);
        settle();
        total++; if (bus.q_count !== 3'd1 || last_tx !== 8'h21) begin bad++; $display("FAIL pause_key got=%0d/%h exp=1/21", bus.q_count, last_tx); end
        send(8'h70, 1'b0);
        total++; if (bus.paused !== 1'b0) begin bad++; $display("FAIL pause_off got=%b exp=0", bus.paused); end
        settle();
        do_step();
        total++; if (bus.dir !== 3'd0) begin bad++; $display("FAIL resume_step got=%0d exp=0", bus.dir); end
        send(8'h61, 1'b0);
        settle();
        send(8'h72, 1'b0);
        total++; if (bus.restart !== 1'b1 || bus.dir !== 3'd7 || bus.q_count !== 3'd0 || bus.overflow !== 1'b0) begin bad++; $display("FAIL restart got=%b/%0d/%0d/%b exp=1/7/0/0", bus.restart, bus.dir, bus.q_count, bus.overflow); end
        tick();
        total++; if (bus.restart !== 1'b0) begin bad++; $display("FAIL restart_pulse got=%b exp=0", bus.restart); end
        settle();
        send(8'h70, 1'b0);
        settle();
        send(8'h72, 1'b0);
        total++; if (bus.paused !== 1'b0) begin bad++; $display("FAIL restart_unpause got=%b exp=0", bus.paused); end
        settle();
        send(8'h62, 1'b0);
        total++; if (bus.background !== 1'b1 || bus.barrier_control !== 1'b0) begin bad++; $display("FAIL bg_pulse got=%b/%b exp=1/0", bus.background, bus.barrier_control); end
        settle();
        send(8'h6b, 1'b0);
        total++; if (bus.barrier_control !== 1'b1 || bus.background !== 1'b0) begin bad++; $display("FAIL barrier_pulse got=%b/%b exp=1/0", bus.barrier_control, bus.background); end
        settle();
        total++; if (last_tx !== 8'h6b) begin bad++; $display("FAIL ctl_echo got=%h exp=6b", last_tx); end
    endtask

    task automatic test_unmapped();
        int c0;
        c0 = tx_cnt;
        send(8'h38, 1'b0);
        settle();
        send(8'h7a, 1'b0);
        settle();
        total++; if (tx_cnt !== c0 || bus.q_count !== 3'd0) begin bad++; $display("FAIL unmapped got=%0d/%0d exp=%0d/0", tx_cnt, bus.q_count, c0); end
    endtask

    task automatic test_busy();
        int c0;
        c0 = tx_cnt;
        bus.tx_busy = 1'b1;
        send(8'h77, 1'b0);
        send(8'h61, 1'b0);
        repeat (5) tick();
        total++; if (tx_cnt !== c0 || bus.q_count !== 3'd2) begin bad++; $display("FAIL busy_hold got=%0d/%0d exp=%0d/2", tx_cnt, bus.q_count, c0); end
        bus.tx_busy = 1'b0;
        settle();
        settle();
        total++; if (tx_cnt !== c0 + 1 || last_tx !== 8'h77) begin bad++; $display("FAIL busy_release got=%0d/%h exp=%0d/77", tx_cnt, last_tx, c0 + 1); end
        total++; if (busy_viol !== 0) begin bad++; $display("FAIL tx_while_busy got=%0d exp=0", busy_viol); end
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b0;
        #1;
        total++; if (bus.q_count !== 3'd0 || bus.dir !== 3'd7) begin bad++; $display("FAIL async_reset got=%0d/%0d exp=0/7", bus.q_count, bus.dir); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        tx_cnt       = 0;
        busy_viol    = 0;
        last_tx      = 8'h00;
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.step     = 1'b0;
        bus.tx_busy  = 1'b0;
        test_reset();
        test_reject();
        test_overflow();
        test_same_cycle();
        test_pause_restart();
        test_unmapped();
        test_busy();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
